// File: rtl/csel_addsub_pkg.sv
// csel_addsub_pkg: shared defaults, op encoding and configuration check for the carry-select add/sub pipe
package csel_addsub_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 8;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    function automatic bit cfg_ok(input int width, input int block);
        return block >= 1 && block <= width && width % block == 0;
    endfunction
endpackage

// File: rtl/csel_block.sv
// csel_block: BLOCK-bit carry-select slice, both carry-in cases precomputed then muxed
module csel_block
    import csel_addsub_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [BLOCK-1:0] s0, s1;
    logic co0, co1;
    assign {co0, s0} = {1'b0, x} + {1'b0, y};
    assign {co1, s1} = {1'b0, x} + {1'b0, y} + (BLOCK+1)'(1);
    assign s = ci ? s1 : s0;
    assign co = ci ? co1 : co0;
    // carry into the MSB falls out of the MSB sum bit and its operands
    assign c_msb_in = s[BLOCK-1] ^ x[BLOCK-1] ^ y[BLOCK-1];
endmodule

// File: rtl/csel_addsub_pipe.sv
// csel_addsub_pipe: pipelined carry-select adder/subtractor, one BLOCK-bit slice resolved per stage
module csel_addsub_pipe
    import csel_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NSTG = WIDTH / BLOCK;
    if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
        $error("csel_addsub_pipe: WIDTH must be a positive multiple of BLOCK");
    end
    logic [WIDTH-1:0] a_q [NSTG], b_q [NSTG], s_q [NSTG];
    logic [WIDTH-1:0] x_a [NSTG], x_b [NSTG], x_s [NSTG], s_n [NSTG];
    logic [BLOCK-1:0] s_blk [NSTG];
    logic [NSTG-1:0] v_q, c_q, x_v, x_c, c_blk, c_msb;
    logic ov_q, z_q, stall, unused_tail;
    assign stall = v_q[NSTG-1] && !out_ready;
    assign in_ready = !stall;
    // operands shift down one slice per stage so every stage works on bits [BLOCK-1:0]
    always_comb begin
        x_a[0] = a;
        x_b[0] = b ^ {WIDTH{sub == OP_SUB}};
        x_s[0] = '0;
        x_c[0] = (sub == OP_ADD) ? cin : 1'b1;
        x_v[0] = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            x_a[k] = a_q[k-1];
            x_b[k] = b_q[k-1];
            x_s[k] = s_q[k-1];
            x_c[k] = c_q[k-1];
            x_v[k] = v_q[k-1];
        end
    end
    for (genvar i = 0; i < NSTG; i++) begin : g_stg
        csel_block #(.BLOCK(BLOCK)) u_blk (
            .x        (x_a[i][BLOCK-1:0]),
            .y        (x_b[i][BLOCK-1:0]),
            .ci       (x_c[i]),
            .s        (s_blk[i]),
            .co       (c_blk[i]),
            .c_msb_in (c_msb[i])
        );
        // finished slices enter at the top and settle into place after the last stage
        assign s_n[i] = WIDTH'({s_blk[i], x_s[i]} >> BLOCK);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            ov_q <= 1'b0;
            z_q <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q <= x_v;
            c_q <= c_blk;
            ov_q <= c_msb[NSTG-1] ^ c_blk[NSTG-1];
            z_q <= ~|s_n[NSTG-1];
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= x_a[k] >> BLOCK;
                b_q[k] <= x_b[k] >> BLOCK;
                s_q[k] <= s_n[k];
            end
        end
    end
    assign unused_tail = ^{a_q[NSTG-1], b_q[NSTG-1], c_msb};
    assign out_valid = v_q[NSTG-1];
    assign result = s_q[NSTG-1];
    assign carry_out = c_q[NSTG-1];
    assign overflow = ov_q;
    assign zero = z_q;
endmodule

// File: tb/tb_csel_addsub_pipe.sv
// tb_csel_addsub_pipe: directed table and sequence checks for the carry-select add/sub pipe
module tb_csel_addsub_pipe;
    localparam int NSTG = 4;
    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        exp_t        e;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid, in_ready, sub, cin, out_valid, out_ready, carry_out, overflow, zero;
    logic [31:0] a, b, result;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    exp_t exp_q[$];
    int out_cyc_q[$];
    vec_t tbl[11];
    csel_addsub_pipe #(.WIDTH(32), .BLOCK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
        logic [32:0] r;
        logic [31:0] ye;
        exp_t e;
        ye = s ? ~y : y;
        r = {1'b0, x} + {1'b0, ye} + 33'(s ? 1'b1 : c);
        e.res = r[31:0];
        e.co = r[32];
        e.ov = (x[31] == ye[31]) && (r[31] != x[31]);
        e.z = (r[31:0] == 32'h0);
        return e;
    endfunction
    // scoreboard: each output transfer must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result=%h with no op outstanding", result);
            end else begin
                chk("output {res,co,ov,z}", 64'({result, carry_out, overflow, zero}), 64'(exp_q.pop_front()));
            end
            out_cyc_q.push_back(cyc);
        end
    end
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tc, input exp_t e);
        int n = 0;
        a = ta;
        b = tb;
        sub = ts;
        cin = tc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout in_ready", 64'(in_ready), 64'(1));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain outstanding", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, " result"}, 64'(result), 64'(0));
        chk({tag, " carry_out"}, 64'(carry_out), 64'(0));
        chk({tag, " overflow"}, 64'(overflow), 64'(0));
        chk({tag, " zero"}, 64'(zero), 64'(0));
        chk({tag, " in_ready"}, 64'(in_ready), 64'(1));
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        tbl[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, '{32'h0000_0008, 1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        tbl[3]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        tbl[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, '{32'h0000_0007, 1'b1, 1'b0, 1'b0}};
        tbl[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tbl[7]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0}};
        tbl[8]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{32'h2345_6789, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        tbl[10] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        sub = 1'b0;
        cin = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, tbl[i].e);
            drain();
            chk($sformatf("latency vec%0d", i), 64'(out_cyc_q[$] - acc_cyc), 64'(NSTG - 1));
        end
        out_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] sa, sb;
            sa = 32'(i) * 32'h1111_1111;
            sb = 32'hF0F0_F0F0 ^ 32'(i << 4);
            chk($sformatf("stream in_ready op%0d", i), 64'(in_ready), 64'(1));
            send(sa, sb, i[0], i[1], model(sa, sb, i[0], i[1]));
        end
        drain();
        chk("stream count", 64'(out_cyc_q.size()), 64'(8));
        chk("stream consecutive", 64'(out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[0]), 64'(7));
        out_cyc_q.delete();
        fork
            for (int i = 0; i < 6; i++) begin
                logic [31:0] pa;
                pa = 32'h0100_0000 * 32'(i + 1) + 32'(i);
                send(pa, 32'h00FF_FFFF, i % 3 == 0, 1'b1, model(pa, 32'h00FF_FFFF, i % 3 == 0, 1'b1));
            end
            begin
                logic [31:0] held;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = result;
                chk("stall out_valid", 64'(out_valid), 64'(1));
                chk("stall in_ready", 64'(in_ready), 64'(0));
                repeat (4) begin
                    @(negedge clk);
                    chk("stall in_ready", 64'(in_ready), 64'(0));
                    chk("stall out_valid held", 64'(out_valid), 64'(1));
                    chk("stall result held", 64'(result), 64'(held));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("backpressure count", 64'(out_cyc_q.size()), 64'(6));
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, model(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1));
        send(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, model(32'h10, 32'h1, 1'b1, 1'b0));
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        chk("inflight out_valid", 64'(out_valid), 64'(1));
        chk("inflight carry_out", 64'(carry_out), 64'(1));
        chk("inflight zero", 64'(zero), 64'(1));
        #1 rst_n = 1'b0;
        #1 chk_reset("midop_reset");
        exp_q.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h2, 32'h2, 1'b0, 1'b0, '{32'h4, 1'b0, 1'b0, 1'b0});
        drain();
        chk("post_reset latency", 64'(out_cyc_q[$] - acc_cyc), 64'(NSTG - 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
